// File: rtl/binary_div_pkg.sv
// Shared widths, FSM encoding and constants for the 26/13 sequential restoring divider.
package binary_div_pkg;

  localparam int N_W   = 26;
  localparam int D_W   = 13;
  localparam int ITERS = 13;
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [D_W-1:0]   Q_ERR    = 13'h1FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/binary_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when the trial value is large enough.
module binary_div_step
  import binary_div_pkg::*;
(
  input  logic [D_W-1:0] rem_i,
  input  logic           bit_i,
  input  logic [D_W-1:0] div_i,
  output logic [D_W-1:0] rem_o,
  output logic           q_bit_o
);

  logic [D_W:0] trial;

  // The incoming remainder is always below the divisor, so the result fits in D_W bits.
  always_comb begin
    trial   = {rem_i, bit_i};
    q_bit_o = (trial >= {1'b0, div_i});
    rem_o   = q_bit_o ? D_W'(trial - {1'b0, div_i}) : trial[D_W-1:0];
  end

endmodule

// File: rtl/binary_div_26_13_seq.sv
// Sequential 26/13 unsigned restoring divider, one quotient bit per enabled clock.
// Define BINARY_DIV_REM_EN to export the remainder on R; otherwise R is tied to zero.
module binary_div_26_13_seq
  import binary_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [N_W-1:0]   N,
  input  logic [D_W-1:0]   D,
  output logic [D_W-1:0]   Q,
  output logic [D_W-1:0]   R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [D_W-1:0]   q_out_q, q_out_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [D_W-1:0]   rem_q, rem_d;
  logic [D_W-1:0]   div_q, div_d;
  logic [D_W-1:0]   nlo_q, nlo_d;
  logic [D_W-2:0]   qw_q, qw_d;

  logic [D_W-1:0]   step_rem;
  logic             step_qbit;

`ifdef BINARY_DIV_REM_EN
  logic [D_W-1:0]   r_out_q, r_out_d;
`endif

  binary_div_step u_step (
    .rem_i   (rem_q),
    .bit_i   (nlo_q[D_W-1]),
    .div_i   (div_q),
    .rem_o   (step_rem),
    .q_bit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    div_d   = div_q;
    nlo_d   = nlo_q;
    qw_d    = qw_q;
`ifdef BINARY_DIV_REM_EN
    r_out_d = r_out_q;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            div_d = D;
            nlo_d = N[D_W-1:0];
            rem_d = N[N_W-1:D_W];
            qw_d  = '0;
            cnt_d = '0;
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            if (D == '0) begin
              state_d = DONE;
              dbz_d   = 1'b1;
              q_out_d = Q_ERR;
`ifdef BINARY_DIV_REM_EN
              r_out_d = N[D_W-1:0];
`endif
            end else if (N[N_W-1:D_W] >= D) begin
              // Quotient would need more than D_W bits.
              state_d = DONE;
              ovf_d   = 1'b1;
              q_out_d = Q_ERR;
`ifdef BINARY_DIV_REM_EN
              r_out_d = '0;
`endif
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = step_rem;
          nlo_d = {nlo_q[D_W-2:0], 1'b0};
          qw_d  = {qw_q[D_W-3:0], step_qbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            q_out_d = {qw_q, step_qbit};
`ifdef BINARY_DIV_REM_EN
            r_out_d = step_rem;
`endif
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_out_q <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BINARY_DIV_REM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= r_out_d;
    end
  end
  assign R = r_out_q;
`else
  assign R = '0;
`endif

  // Working datapath carries no reset; it is fully reloaded on every accept.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    div_q <= div_d;
    nlo_q <= nlo_d;
    qw_q  <= qw_d;
  end

  assign Q           = q_out_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_binary_div_26_13_seq.sv
// Scoreboard bench for binary_div_26_13_seq; honours BINARY_DIV_REM_EN for remainder checks.
module tb_binary_div_26_13_seq;

`ifdef BINARY_DIV_REM_EN
  localparam bit REM_ON = 1'b1;
`else
  localparam bit REM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, start;
  logic [25:0] N;
  logic [12:0] D;
  logic [12:0] Q, R;
  logic        busy, done, div_by_zero, overflow;

  always #5 clk = ~clk;

  binary_div_26_13_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .N(N), .D(D),
    .Q(Q), .R(R), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  typedef struct {
    logic [12:0] q;
    logic [12:0] r;
    logic        dbz;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   chk_next = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] rx(input logic [12:0] r);
    return REM_ON ? r : 13'd0;
  endfunction

  // Monitor: pops one expectation per done pulse that is about to be consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_next) begin
        chk("done_one_cycle", done, 1'b0);
        chk_next = 1'b0;
      end
      if (done && en) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk("Q", Q, mon_e.q);
          chk("R", R, rx(mon_e.r));
          chk("div_by_zero", div_by_zero, mon_e.dbz);
          chk("overflow", overflow, mon_e.ovf);
          chk("done_cycle", cyc, mon_e.cyc);
          chk("busy_in_done", busy, 1'b1);
          chk_next = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [25:0] n, input logic [12:0] d,
                       input logic [12:0] q, input logic [12:0] r,
                       input logic dbz, input logic ovf, input int extra);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.ovf = ovf;
    e.cyc = cyc + 1 + ((dbz || ovf) ? 0 : 13) + extra;
    sb.push_back(e);
    N = n;
    D = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    N = 26'($urandom);
    D = 13'($urandom);
  endtask

  task automatic issue_model(input logic [25:0] n, input logic [12:0] d);
    if (d == 13'd0)
      issue(n, d, 13'h1FFF, n[12:0], 1'b1, 1'b0, 0);
    else if (n[25:13] >= d)
      issue(n, d, 13'h1FFF, 13'd0, 1'b0, 1'b1, 0);
    else
      issue(n, d, 13'(n / d), 13'(n % d), 1'b0, 1'b0, 0);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) begin
      chk("drain_timeout", 1'b1, 1'b0);
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 40) chk("wait_done_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; N = '0; D = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_Q", Q, 13'd0);
    chk("rst_R", R, 13'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    // Largest legal quotient, issued on the first edge after reset release.
    issue(26'd67092481, 13'd8191, 13'd8191, 13'd0, 1'b0, 1'b0, 0);
    drain();

    // done must hold while en is low in DONE.
    issue(26'd1000, 13'd7, 13'd142, 13'd6, 1'b0, 1'b0, 3);
    wait_done();
    en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_hold_en0", done, 1'b1);
    end
    en = 1'b1;
    drain();
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_Q", Q, 13'd142);
    chk("hold_R", R, rx(13'd6));

    // start during the DONE->IDLE edge must be ignored.
    issue(26'd0, 13'd1, 13'd0, 13'd0, 1'b0, 1'b0, 0);
    wait_done();
    start = 1'b1; N = 26'd5; D = 13'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("start_in_done_ignored", busy, 1'b0);
    drain();

    issue(26'd12345, 13'd0, 13'h1FFF, 13'd4153, 1'b1, 1'b0, 0);
    drain();
    issue(26'd8192, 13'd1, 13'h1FFF, 13'd0, 1'b0, 1'b1, 0);
    drain();
    issue(26'd8191, 13'd1, 13'd8191, 13'd0, 1'b0, 1'b0, 0);
    drain();

    // Mid-CALC async reset discards the operation.
    issue(26'd500, 13'd3, 13'd166, 13'd2, 1'b0, 1'b0, 0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_Q", Q, 13'd0);
    chk("midrst_R", R, 13'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_dbz", div_by_zero, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(26'd9, 13'd2, 13'd4, 13'd1, 1'b0, 1'b0, 0);
    drain();

    // Stall mid-CALC for 4 cycles while a second start is attempted.
    issue(26'd100000, 13'd77, 13'd1298, 13'd54, 1'b0, 1'b0, 4);
    repeat (3) begin @(posedge clk); #1; end
    en = 1'b0; start = 1'b1; N = 26'd5; D = 13'd1;
    repeat (4) begin @(posedge clk); #1; end
    en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [25:0] rn;
      logic [12:0] rd;
      rd = 13'($urandom_range(0, 8191));
      if (i % 10 == 9) rd = 13'd0;
      rn = 26'($urandom);
      if (i % 3 != 0 && rd != 13'd0) rn = 26'(rn % ({13'd0, rd} << 13));
      issue_model(rn, rd);
      drain();
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_empty_at_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
